// File: rtl/arith_pkg.sv
// Shared types for the arith scheduler: op encoding, data width, in-flight stage record.
// Consumed by arith_sched and rr_arbiter (ARITH_SCHED_RR_EN selects the arbitration mode).
package arith_pkg;

  localparam int DATA_W     = 32;
  localparam int STAGE_ID_W = 3;

  typedef enum logic [1:0] {
    ARITH_ADD = 2'd0,
    ARITH_MUL = 2'd1,
    ARITH_EQ  = 2'd2,
    ARITH_NOP = 2'd3
  } arith_op_e;

  typedef struct packed {
    logic                  valid;
    logic [STAGE_ID_W-1:0] id;
    arith_op_e             op;
  } stage_t;

  // Picks the unit result that belongs to the op; reserved op yields zero.
  function automatic logic [DATA_W-1:0] select_result(input arith_op_e op,
                                                      input logic [DATA_W-1:0] sum,
                                                      input logic [DATA_W-1:0] mult,
                                                      input logic eq);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      ARITH_ADD: res = sum;
      ARITH_MUL: res = mult;
      ARITH_EQ:  res = {{(DATA_W-1){1'b0}}, eq};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arith_sched_rr_arbiter.sv
// Requester arbiter: round-robin when ARITH_SCHED_RR_EN is defined, otherwise
// fixed priority with the lowest index winning and no pointer state.
module rr_arbiter
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef ARITH_SCHED_RR_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;

  // Search starts at ptr and wraps; ptr always holds last winner + 1.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  logic unused_ok;

  assign grant     = req & (~req + NUM_REQ'(1));
  assign unused_ok = ^{clk, rst, advance};
`endif

endmodule

// File: rtl/arith_sched.sv
// Shares one registered arith unit among NUM_REQ requesters with fixed 2-cycle latency.
// Arbitration mode is chosen by the ARITH_SCHED_RR_EN macro (see rr_arbiter).
module arith_sched
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0][1:0]        req_op,
  output logic [DATA_W-1:0]              unit_a,
  output logic [DATA_W-1:0]              unit_b,
  output logic [1:0]                     unit_op,
  input  logic [DATA_W-1:0]              unit_sum,
  input  logic [DATA_W-1:0]              unit_mult,
  input  logic                           unit_eq,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           rsp_err,
  output logic [ID_W-1:0]                rsp_id,
  output logic                           idle
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  stage_t             s1;
  stage_t             s2;
  logic [DATA_W-1:0]  s2_data;
  logic               unused_stage_bits;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Grants are masked while reset is held so nobody sees an accept.
  assign req_ready = rst ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  always_comb begin
    unit_a  = '0;
    unit_b  = '0;
    unit_op = ARITH_NOP;
    if (accept) begin
      unit_a  = req_a[grant_idx];
      unit_b  = req_b[grant_idx];
      unit_op = req_op[grant_idx];
    end
  end

  // Stage 1 waits for the unit register; stage 2 captures the selected result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      s2_data <= '0;
    end else begin
      if (accept) begin
        s1.valid <= 1'b1;
        s1.id    <= STAGE_ID_W'(grant_idx);
        s1.op    <= arith_op_e'(req_op[grant_idx]);
      end else begin
        s1 <= '0;
      end
      s2      <= s1;
      s2_data <= s1.valid ? select_result(s1.op, unit_sum, unit_mult, unit_eq) : '0;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2.valid) rsp_valid[s2.id[ID_W-1:0]] = 1'b1;
  end

  assign rsp_data          = s2_data;
  assign rsp_id            = s2.valid ? s2.id[ID_W-1:0] : '0;
  assign rsp_err           = s2.valid && (s2.op == ARITH_NOP);
  assign idle              = !rst || (!s1.valid && !s2.valid && (req_valid == '0));
  assign unused_stage_bits = ^s2.id;

endmodule

// File: doc/arith_sched.md
ARITH_SCHED -- requirements
Module: arith_sched

Interface
- REQ-001: Parameter NUM_REQ, default 4, number of requesters sharing one arith_lite unit (legal 2..8).
- REQ-002: Parameter ID_W, default $clog2(NUM_REQ), requester index width.
- REQ-003: Reset rst, asynchronous, active-low; clock clk.
- REQ-004: clk  in  1  rising-edge clock, shared with the arith unit.
- REQ-005: rst  in  1  asynchronous active-low reset.
- REQ-006: req_valid  in  NUM_REQ  per-requester request valid.
- REQ-007: req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- REQ-008: req_a, req_b  in  NUM_REQ x 32  per-requester operands.
- REQ-009: req_op  in  NUM_REQ x 2  per-requester op: 0 add, 1 mul, 2 eq, 3 reserved.
- REQ-010: unit_a, unit_b  out  32  operands to the arith unit; unit_op  out  2  op to the arith unit.
- REQ-011: unit_sum, unit_mult  in  32; unit_eq  in  1; registered arith unit results.
- REQ-012: rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- REQ-013: rsp_data  out  32  result; rsp_err  out  1  reserved-op flag; rsp_id  out  ID_W  owner index.
- REQ-014: idle  out  1  high when no operation is in flight and no request is pending.

Function
- REQ-015: Grant SHALL be combinational from req_valid and arbitration state; req_ready[i] high only for the granted requester.
- REQ-016: A request SHALL be accepted in a cycle where req_valid[i] and req_ready[i] are both high; one acceptance per cycle maximum.
- REQ-017: unit_a/unit_b/unit_op SHALL carry the granted requester's operands in the accept cycle; otherwise zero with unit_op=3 (no-op).
- REQ-018: Request accepted in cycle k SHALL produce rsp_valid in cycle k+2 (fixed 2-cycle latency), throughput 1 op/cycle.
- REQ-019: A 2-stage in-flight pipeline SHALL carry {valid, id, op}; stage 2 selects the response.
- REQ-020: rsp_data SHALL be unit_sum for op 0, unit_mult for op 1, {31'b0, unit_eq} for op 2, zero for op 3.
- REQ-021: Op 3 SHALL be accepted, issued as no-op, and returned with rsp_err=1, rsp_data=0.
- REQ-022: Responses SHALL have no backpressure; requester must sample rsp_valid in the pulse cycle.
- REQ-023: No valid requests -> no grant, pointer unchanged, no-op driven to the unit.
- REQ-024: rsp_id, rsp_data, rsp_err SHALL be zero when no rsp_valid bit is high.
- REQ-025: idle SHALL be high when both pipeline stages are empty and req_valid is all-zero.

Reset
- REQ-026: On rst low: rsp_valid=0, rsp_data=0, rsp_err=0, rsp_id=0, req_ready=0, idle=1, pipeline cleared, RR pointer=0.
- REQ-027: Reset mid-operation SHALL discard all in-flight ops; no response emitted for them after reset release.
- REQ-028: First grant SHALL be possible in the first cycle after rst deasserts.

Configuration
- REQ-029: Macro ARITH_SCHED_RR_EN defined: round-robin; search starts at index after last accepted requester, pointer wraps NUM_REQ-1 -> 0, updates only on acceptance.
- REQ-030: ARITH_SCHED_RR_EN undefined: fixed priority, lowest index wins; no pointer state.

Structure
- REQ-031: Package arith_pkg SHALL hold op enum (ARITH_ADD=0, ARITH_MUL=1, ARITH_EQ=2, ARITH_NOP=3), DATA_W=32, and the in-flight stage struct {valid, id, op}.
- REQ-032: Arbitration SHALL live in sub-module rr_arbiter (req vector in, one-hot grant out, advance strobe in); arith_sched instantiates it once.

Verification
- REQ-033: Single req0 add 5+7 accepted cycle k -> rsp_valid[0] in k+2, rsp_data=12, rsp_err=0, rsp_id=0.
- REQ-034: All four valid continuously, RR_EN defined -> grants 0,1,2,3,0 in consecutive cycles; responses in same order two cycles later.
- REQ-035: Same stimulus, RR_EN undefined -> req0 granted every cycle, others stalled with req_ready=0.
- REQ-036: req2 mul 0x10000 x 0x10000 then eq 9==9 back-to-back -> rsp_data 0x0 then 0x1, consecutive cycles.
- REQ-037: req1 op 3 -> rsp_err=1, rsp_data=0 at k+2; rst asserted at k+1 with op in flight -> no rsp_valid after release, idle=1.
